// File: rtl/crypto_wallet_led_sequencer.sv
// Wallet status LED sequencer: Avalon-MM CPU pattern, fixed-priority
// hardware requesters, tick-based blink and rotate effects.
module crypto_wallet_led_sequencer #(
  parameter int          NUM_REQ        = 4,
  parameter int          HOLD_TICKS     = 8,
  parameter logic [23:0] DEFAULT_PERIOD = 24'd4_999_999
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             address,
  input  logic                   chipselect,
  input  logic                   write_n,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_pattern,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             out_port
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [NUM_REQ-1:0]   owner, owner_n;
  logic [HW-1:0]        hold, hold_n;

  logic [7:0]           data_q;
  logic [2:0]           ctrl_q;
  logic [23:0]          period_q;
  logic [23:0]          tick_cnt;
  logic                 phase;
  logic                 tick;

  logic                 wr;
  logic                 wr_data;
  logic                 wr_ctrl;
  logic                 wr_period;

  logic                 blink_en;
  logic                 hw_en;
  logic                 rotate_en;

  logic [7:0]           owner_pat;
  logic [7:0]           pat_sel;
  logic [7:0]           out_n;
  logic [NUM_REQ-1:0]   grant_n;
  logic [7:0]           stat_grant;

  logic                 unused_wd;

  assign unused_wd = ^writedata[31:24];

  assign wr        = chipselect & ~write_n;
  assign wr_data   = wr & (address == 2'd0);
  assign wr_ctrl   = wr & (address == 2'd1);
  assign wr_period = wr & (address == 2'd2);

  assign blink_en  = ctrl_q[0];
  assign hw_en     = ctrl_q[1];
  assign rotate_en = ctrl_q[2];

  assign tick = (tick_cnt == period_q);

  // Tick divisor: counts 0..PERIOD, restarts on a PERIOD write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (wr_period) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 24'd1;
    end
  end

  // CPU registers, rotate effect and blink phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      ctrl_q   <= '0;
      period_q <= DEFAULT_PERIOD;
      phase    <= 1'b0;
    end else begin
      if (wr_data) begin
        data_q <= writedata[7:0];
      end else if (rotate_en && tick) begin
        data_q <= {data_q[6:0], data_q[7]};
      end
      if (wr_ctrl) begin
        ctrl_q <= writedata[2:0];
      end
      if (wr_period) begin
        period_q <= writedata[23:0];
      end
      if (tick) begin
        phase <= ~phase;
      end
    end
  end

  // Arbiter state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      hold  <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      hold  <= hold_n;
    end
  end

  // Arbiter next state: grant lowest index, hold for HOLD_TICKS ticks, then gap
  always_comb begin
    state_n = state;
    owner_n = owner;
    hold_n  = hold;
    unique case (state)
      IDLE: begin
        if (hw_en && (|req)) begin
          owner_n = req & (~req + NUM_REQ'(1));
          hold_n  = '0;
          state_n = SHOW;
        end
      end
      SHOW: begin
        if (!hw_en) begin
          state_n = IDLE;
        end else if (tick) begin
          if (hold == HOLD_LAST) begin
            state_n = GAP;
          end else begin
            hold_n = hold + 1'b1;
          end
        end
      end
      GAP: begin
        if (!hw_en || tick) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Pattern selection with blink blanking
  always_comb begin
    owner_pat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner[i]) begin
        owner_pat = owner_pat | req_pattern[8*i +: 8];
      end
    end
    pat_sel = '0;
    grant_n = '0;
    unique case (state)
      IDLE: pat_sel = data_q;
      SHOW: begin
        pat_sel = owner_pat;
        grant_n = owner;
      end
      default: pat_sel = '0;
    endcase
    out_n = pat_sel;
    if (state != GAP && blink_en && phase) begin
      out_n = '0;
    end
  end

  // Registered LED drive and grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_port <= '0;
      grant    <= '0;
    end else begin
      out_port <= out_n;
      grant    <= grant_n;
    end
  end

  // Zero-wait read mux
  always_comb begin
    stat_grant = '0;
    stat_grant[NUM_REQ-1:0] = grant;
    readdata = '0;
    unique case (address)
      2'd0: readdata = {24'd0, data_q};
      2'd1: readdata = {29'd0, ctrl_q};
      2'd2: readdata = {8'd0, period_q};
      default: readdata = {21'd0, state, phase, stat_grant};
    endcase
  end

endmodule

// File: tb/tb_crypto_wallet_led_sequencer.sv
// Randomized scoreboard bench for the wallet LED sequencer.
// Reference model tracks ticks, ownership and effects per cycle.
module tb_crypto_wallet_led_sequencer;

  localparam int HOLD = 8;
  localparam int unsigned DEF_P = 4_999_999;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  req;
  logic [31:0] req_pattern;
  logic [3:0]  grant;
  logic [7:0]  out_port;

  crypto_wallet_led_sequencer #(
    .NUM_REQ(4),
    .HOLD_TICKS(HOLD),
    .DEFAULT_PERIOD(24'd4_999_999)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .req(req),
    .req_pattern(req_pattern),
    .grant(grant),
    .out_port(out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  out;
    logic [3:0]  gnt;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // model: mode 0 = show CPU data, 1 = show owner, 2 = gap
  logic [7:0]  m_data;
  logic [2:0]  m_ctrl;
  int unsigned m_period;
  int unsigned m_cnt;
  bit          m_phase;
  int          m_mode;
  int          m_owner;
  int          m_left;
  logic [7:0]  m_out;
  logic [3:0]  m_grant;
  logic [31:0] pats;

  task automatic model_reset();
    m_data = 0; m_ctrl = 0; m_period = DEF_P; m_cnt = 0;
    m_phase = 0; m_mode = 0; m_owner = 0; m_left = 0;
    m_out = 0; m_grant = 0;
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0: return {24'd0, m_data};
      2'd1: return {29'd0, m_ctrl};
      2'd2: return m_period;
      default: return (m_mode << 9) | (32'(m_phase) << 8) | 32'(m_grant);
    endcase
  endfunction

  task automatic model_step(input bit wr, input logic [1:0] a,
                            input logic [31:0] wd, input logic [3:0] rq,
                            input logic [31:0] pt);
    bit tk;
    bit hw;
    logic [7:0] sel;
    logic [3:0] g;
    tk = (m_cnt == m_period);
    hw = m_ctrl[1];
    g = 0;
    if (m_mode == 0) sel = m_data;
    else if (m_mode == 1) begin
      sel = pt[8*m_owner +: 8];
      g = 4'(1 << m_owner);
    end else sel = 0;
    if (m_mode != 2 && m_ctrl[0] && m_phase) sel = 0;
    if (m_mode == 0) begin
      if (hw && rq != 0) begin
        m_owner = 0;
        while (!rq[m_owner]) m_owner++;
        m_left = HOLD;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (!hw) m_mode = 0;
      else if (tk) begin
        m_left--;
        if (m_left == 0) m_mode = 2;
      end
    end else begin
      if (!hw || tk) m_mode = 0;
    end
    if (wr && a == 0) m_data = wd[7:0];
    else if (m_ctrl[2] && tk) m_data = {m_data[6:0], m_data[7]};
    if (wr && a == 1) m_ctrl = wd[2:0];
    if (wr && a == 2) begin
      m_period = wd[23:0];
      m_cnt = 0;
    end else m_cnt = tk ? 0 : m_cnt + 1;
    if (tk) m_phase = !m_phase;
    m_out = sel;
    m_grant = g;
  endtask

  task automatic cyc(input bit rst, input bit wr, input logic [1:0] a,
                     input logic [31:0] wd, input logic [3:0] rq);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    chipselect = wr;
    write_n = !wr;
    address = a;
    writedata = wd;
    req = rq;
    req_pattern = pats;
    if (rst) model_reset();
    e.out = m_out;
    e.gnt = m_grant;
    e.rd = model_rd(a);
    q.push_back(e);
    if (!rst) model_step(wr, a, wd, rq, pats);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd,
                        input logic [3:0] rq);
    cyc(0, 1, a, wd, rq);
  endtask

  task automatic idle(input int n, input logic [1:0] a,
                      input logic [3:0] rq);
    for (int i = 0; i < n; i++) cyc(0, 0, a, 0, rq);
  endtask

  // monitor: outputs presented every cycle, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks += 3;
      if (out_port !== e.out) begin
        errors++;
        $display("FAIL out_port t=%0t got %h want %h", $time, out_port, e.out);
      end
      if (grant !== e.gnt) begin
        errors++;
        $display("FAIL grant t=%0t got %b want %b", $time, grant, e.gnt);
      end
      if (readdata !== e.rd) begin
        errors++;
        $display("FAIL readdata t=%0t a=%0d got %h want %h",
                 $time, address, readdata, e.rd);
      end
    end
  end

  initial begin
    reset = 1; chipselect = 0; write_n = 1; address = 0;
    writedata = 0; req = 0; req_pattern = 0;
    pats = 32'h00F0_0F00;
    model_reset();
    cyc(1, 0, 2, 0, 0);
    cyc(1, 0, 3, 0, 0);
    // CPU path with rotate
    wr_reg(2, 3, 0);
    wr_reg(0, 32'h81, 0);
    wr_reg(1, 4, 0);
    idle(12, 0, 0);
    // arbitration with no pre-empt
    wr_reg(1, 0, 0);
    wr_reg(0, 0, 0);
    wr_reg(2, 0, 0);
    wr_reg(1, 2, 4'b0110);
    idle(14, 3, 4'b0110);
    idle(6, 3, 4'b0101);
    idle(16, 3, 4'b0001);
    idle(4, 3, 0);
    // blink, then hold when blink is cleared
    wr_reg(1, 0, 0);
    wr_reg(2, 1, 0);
    wr_reg(0, 32'hAA, 0);
    wr_reg(1, 1, 0);
    idle(9, 3, 0);
    wr_reg(1, 0, 0);
    idle(5, 0, 0);
    // abort mid-SHOW
    wr_reg(2, 0, 0);
    wr_reg(1, 2, 4'b1000);
    idle(4, 3, 4'b1000);
    wr_reg(1, 0, 4'b1000);
    idle(4, 3, 4'b1000);
    // DATA write on a rotate tick
    wr_reg(1, 4, 0);
    wr_reg(0, 32'h5A, 0);
    idle(3, 0, 0);
    // reset mid-SHOW
    wr_reg(1, 2, 4'b0100);
    idle(4, 3, 4'b0100);
    cyc(1, 0, 3, 0, 4'b0100);
    cyc(1, 0, 2, 0, 4'b0100);
    idle(3, 3, 4'b0100);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit wr;
      logic [1:0] a;
      logic [31:0] wd;
      wr = ($urandom_range(0, 3) == 0);
      a = 2'($urandom);
      wd = $urandom;
      if (wr && a == 2) wd = $urandom_range(0, 4);
      if ($urandom_range(0, 40) == 0) pats = $urandom;
      cyc(($urandom_range(0, 700) == 0), wr, a, wd, 4'($urandom));
    end
    idle(2, 0, 0);
    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
